// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device-generated clock edges and checks the ACK.
module ps2_command_out #(
  parameter int INHIBIT_CYCLES        = 6000,
  parameter int START_TIMEOUT_CYCLES  = 750000,
  parameter int PACKET_TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > PACKET_TIMEOUT_CYCLES) ? MAX_A : PACKET_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(PACKET_TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_DATA, S_PARITY,
    S_ACK, S_WAIT_IDLE, S_DONE, S_ERR_TO, S_ERR_NACK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       bit_q, bit_d;
  logic [8:0]       sh_q, sh_d;
  logic             clk_low_q, clk_low_d, dat_low_q, dat_low_d;
  logic             busy_q, busy_d, done_q, done_d, to_q, to_d, nack_q, nack_d;
  logic             clk_meta_q, clk_sync_q, clk_hist_q, dat_meta_q, dat_sync_q;
  logic             fall;

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign busy                          = busy_q;
  assign command_was_sent              = done_q;
  assign error_communication_timed_out = to_q;
  assign error_no_ack                  = nack_q;

  // Synchronizers reset to the idle (high) level so reset never fakes an edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_hist_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_hist_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall    = clk_hist_q & ~clk_sync_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
      nack_q    <= nack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    dat_low_d = dat_low_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        dat_low_d = 1'b0;
        if (send_command) begin
          state_d   = S_INHIBIT;
          sh_d      = {~^the_command, the_command};
          dat_low_d = (INHIBIT_CYCLES == 1);
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INH_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_inc == INH_LAST) begin
          dat_low_d = 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        if (fall) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_d     = '0;
          dat_low_d = ~sh_q[0];
          sh_d      = sh_q >> 1;
        end else if (cnt_q == START_LAST) begin
          state_d = S_ERR_TO;
        end
      end
      S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (cnt_q == PKT_LAST) begin
          state_d = S_ERR_TO;
        end else begin
          // bit_q is the index of the data bit currently on the wire; the
          // shift register places parity at sh_q[0] after the eighth data bit.
          case (state_q)
            S_DATA: if (fall) begin
              dat_low_d = ~sh_q[0];
              sh_d      = sh_q >> 1;
              bit_d     = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: if (fall) begin
              dat_low_d = 1'b0;
              state_d   = S_ACK;
            end
            S_ACK: if (fall) begin
              state_d = dat_sync_q ? S_ERR_NACK : S_WAIT_IDLE;
            end
            default: if (clk_sync_q && dat_sync_q) state_d = S_DONE;
          endcase
        end
      end
      S_DONE, S_ERR_TO, S_ERR_NACK: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR_TO || state_d == S_ERR_NACK) dat_low_d = 1'b0;
    clk_low_d = (state_d == S_INHIBIT);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    to_d      = (state_d == S_ERR_TO);
    nack_d    = (state_d == S_ERR_NACK);
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Self-checking bench for ps2_command_out with a behavioural PS/2 device model.
module tb_ps2_command_out;
  localparam int INH = 60;
  localparam int STO = 750;
  localparam int PTO = 2000;

  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_STALL = 3;
  localparam int O_DONE = 0, O_TO = 1, O_NACK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd = 8'h00;
  logic       send = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  wire        ps2_clk, ps2_dat;
  logic       busy, done, err_to, err_nack;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup pu_clk (ps2_clk);
  pullup pu_dat (ps2_dat);

  ps2_command_out #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .PACKET_TIMEOUT_CYCLES(PTO)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .the_command(cmd),
    .send_command(send),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .busy(busy),
    .command_was_sent(done),
    .error_communication_timed_out(err_to),
    .error_no_ack(err_nack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_to = 0, n_nack = 0;
  int multi_bad = 0, busy_bad = 0;
  logic prev_pulse = 1'b0;

  always @(negedge clk) begin
    if (int'(done) + int'(err_to) + int'(err_nack) > 1) multi_bad++;
    if ((done | err_to | err_nack) && !busy) busy_bad++;
    if (prev_pulse && busy) busy_bad++;
    n_done += int'(done);
    n_to   += int'(err_to);
    n_nack += int'(err_nack);
    prev_pulse = done | err_to | err_nack;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected wire frame: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] c);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = c[i];
    f[9]  = ($countones(c) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic int model_outcome(input int mode);
    if (mode == M_ACK) return O_DONE;
    if (mode == M_NACK) return O_NACK;
    return O_TO;
  endfunction

  task automatic do_txn(input logic [7:0] c, input int mode, input int half,
                        input bit collide, input int abort_p, output logic [10:0] got);
    int n, waitn, d0, t0, k0, outc;
    logic [10:0] exp_f, mask;
    got   = '0;
    exp_f = model_frame(c);
    outc  = model_outcome(mode);
    d0 = n_done; t0 = n_to; k0 = n_nack;
    @(negedge clk); cmd = c; send = 1'b1;
    @(negedge clk); send = 1'b0; cmd = 8'($urandom);
    chk("busy_rise", int'(busy), 1);
    chk("clk_low_after_accept", int'(ps2_clk), 0);
    n = 0;
    while (ps2_clk === 1'b0 && n < INH + 10) begin n++; @(negedge clk); end
    chk("inhibit_len", n, INH);
    got[0] = ps2_dat;
    if (mode == M_SILENT) begin
      waitn = 0;
      while (!(done | err_to | err_nack) && waitn < STO + 50) begin waitn++; @(negedge clk); end
      chk("start_timeout_cycles", waitn, STO);
    end else begin
      repeat (6) @(negedge clk);
      for (int p = 1; p <= 11; p++) begin
        if (mode == M_STALL && p == 4) break;
        if (p == 11 && mode == M_ACK) dev_dat_low = 1'b1;
        dev_clk_low = 1'b1;
        if (abort_p == p) begin
          repeat (8) @(negedge clk);
          chk("dat_before_reset", int'(ps2_dat), int'(exp_f[p]));
          #2 rst = 1'b1;
          #1;
          chk("reset_clk_released", int'(ps2_clk), 0);
          dev_clk_low = 1'b0;
          #0;
          chk("reset_lines_idle", int'(ps2_clk & ps2_dat), 1);
          chk("reset_busy", int'(busy), 0);
          @(negedge clk); rst = 1'b0;
          repeat (3) @(negedge clk);
          chk("reset_no_pulse", (n_done - d0) + (n_to - t0) + (n_nack - k0), 0);
          return;
        end
        if (collide && p == 3) begin
          send = 1'b1; cmd = 8'hAA;
          @(negedge clk);
          send = 1'b0;
          chk("busy_during_collision", int'(busy), 1);
          repeat (half - 1) @(negedge clk);
        end else begin
          repeat (half) @(negedge clk);
        end
        if (p <= 10) got[p] = ps2_dat;
        dev_clk_low = 1'b0;
        repeat (half) @(negedge clk);
        if (p == 11) dev_dat_low = 1'b0;
      end
    end
    waitn = 0;
    while ((n_done - d0) + (n_to - t0) + (n_nack - k0) == 0 && waitn < PTO + 200) begin
      @(negedge clk); waitn++;
    end
    @(negedge clk);
    chk("done_pulses", n_done - d0, int'(outc == O_DONE));
    chk("timeout_pulses", n_to - t0, int'(outc == O_TO));
    chk("nack_pulses", n_nack - k0, int'(outc == O_NACK));
    chk("busy_cleared", int'(busy), 0);
    chk("lines_idle", int'(ps2_clk & ps2_dat), 1);
    mask = (mode == M_ACK || mode == M_NACK) ? 11'h7FF : (mode == M_STALL) ? 11'h00F : 11'h001;
    chk("frame", int'(got & mask), int'(exp_f & mask));
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         mode;
    int         half;
    int         par;
  } vec_t;

  vec_t        tbl[5];
  logic [10:0] got;

  initial begin
    tbl[0] = '{cmd: 8'hED, mode: M_ACK,    half: 20, par: 1};
    tbl[1] = '{cmd: 8'hF4, mode: M_ACK,    half: 15, par: 0};
    tbl[2] = '{cmd: 8'h00, mode: M_SILENT, half: 20, par: 1};
    tbl[3] = '{cmd: 8'hFF, mode: M_NACK,   half: 20, par: 1};
    tbl[4] = '{cmd: 8'h3C, mode: M_STALL,  half: 20, par: 1};

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'(done) + int'(err_to) + int'(err_nack), 0);
    chk("reset_lines", int'(ps2_clk & ps2_dat), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_txn(tbl[i].cmd, tbl[i].mode, tbl[i].half, 1'b0, 0, got);
      if (tbl[i].mode == M_ACK || tbl[i].mode == M_NACK)
        chk("parity_bit", int'(got[9]), tbl[i].par);
    end

    do_txn(8'h3A, M_ACK, 20, 1'b1, 0, got);
    do_txn(8'hED, M_ACK, 20, 1'b0, 5, got);
    do_txn(8'hED, M_ACK, 20, 1'b0, 0, got);

    for (int i = 0; i < 6; i++) begin
      logic [7:0] c;
      int m, h;
      c = 8'($urandom);
      m = int'($urandom_range(0, 3));
      h = int'($urandom_range(10, 30));
      do_txn(c, m, h, 1'b0, 0, got);
    end

    chk("pulses_exclusive", multi_bad, 0);
    chk("busy_pulse_alignment", busy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_command_out.md
# ps2_command_out

Host-to-device PS/2 transmitter that sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), from the FPGA to the keyboard. It is the outbound counterpart of the PS/2 receive path. It shares the PS2_CLK/PS2_DAT open-drain pins with the receiver, sits beside it under the PS/2 controller, and runs entirely in the CLOCK_50 domain.

## Interface
- INHIBIT_CYCLES, 6000: cycles to hold PS2_CLK low before the start bit (120 us at 50 MHz; protocol minimum is 100 us).
- START_TIMEOUT_CYCLES, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT_CYCLES, 100000: maximum cycles from the first falling edge to the ACK sample (2 ms).
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; returns to IDLE and releases both lines immediately.
- the_command  in  8  byte to send; sampled on the accepting cycle.
- send_command  in  1  request; accepted only when busy=0.
- PS2_CLK  inout  1  open-drain: driven 1'b0 or 1'bz, never 1.
- PS2_DAT  inout  1  open-drain: driven 1'b0 or 1'bz, never 1.
- busy  out  1  high from the accept cycle until the cycle of the done or error pulse, inclusive.
- command_was_sent  out  1  one-cycle pulse: device ACK received and lines idle.
- error_communication_timed_out  out  1  one-cycle pulse: a start or packet timeout fired.
- error_no_ack  out  1  one-cycle pulse: data line was high at the ACK sample.

## Operation
- Reset values:
  - busy, command_was_sent, error_communication_timed_out, error_no_ack = 0.
  - PS2_CLK and PS2_DAT = z.
  - Counters = 0; state = IDLE.
- Input conditioning:
  - PS2_CLK and PS2_DAT pass through 2-flop synchronizers, then one history flop.
  - A falling edge is history=1 and sync=0.
- Accept: when send_command=1 and state=IDLE, latch the_command and parity = ~^the_command (odd parity), then go to INHIBIT.
- States and transitions:
  - IDLE: both lines released; wait for an accepted request.
  - INHIBIT: drive PS2_CLK low for INHIBIT_CYCLES. In the last cycle, also drive PS2_DAT low (start bit). Then go to RELEASE.
  - RELEASE: release PS2_CLK and hold PS2_DAT low. Wait for a falling edge, then drive bit0 and go to DATA. If START_TIMEOUT_CYCLES elapse with no edge, go to ERR_TO.
  - DATA: on each falling edge, present the next bit on PS2_DAT, LSB first. A bit of 0 drives low; a bit of 1 releases the line.
    - After bit7 is presented, the next edge presents parity and moves to PARITY.
  - PARITY: the next edge releases PS2_DAT (stop bit) and moves to ACK.
  - ACK: the next falling edge samples sync PS2_DAT.
    - 0: go to WAIT_IDLE.
    - 1: go to ERR_NACK.
  - WAIT_IDLE: wait until synced CLK=1 and DAT=1, then go to DONE.
  - DONE: pulse command_was_sent, then go to IDLE.
  - ERR_TO: release both lines, pulse error_communication_timed_out, then go to IDLE.
  - ERR_NACK: release both lines, pulse error_no_ack, then go to IDLE.
- Packet timer:
  - Starts at the first falling edge.
  - Runs through ACK and WAIT_IDLE.
  - Expiry at PACKET_TIMEOUT_CYCLES goes to ERR_TO.
- send_command is ignored while busy=1; nothing is queued.
- At most one of the three completion pulses is high in any cycle.
- Reset mid-packet: lines release asynchronously, with no done or error pulse. The device's own timeout handles recovery.

## Timing
- Falling-edge detection lags the pin by 3 CLOCK_50 cycles.
- PS2_DAT changes 1 cycle after detection, which is inside the device's clock-low half-period (30–50 us).
- Host falling-edge count per packet is exactly 11: 10 data-changing edges, then 1 ACK edge.
- Accept to PS2_CLK low: 1 cycle.
- PS2_CLK low duration: exactly INHIBIT_CYCLES cycles.
- busy rises in the cycle after send_command is sampled high.
- Pulse to busy=0: busy is 0 in the following cycle, and a new request is accepted in that cycle.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that ACKs. Required response:
  - PS2_CLK low for 6000 cycles.
  - Device samples start=0, data bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - command_was_sent pulses once; busy clears the next cycle.
- Send 0xF4 with the device ACKing: parity=0 on the wire; command_was_sent pulses.
- Send 0x00 with the device never clocking: error_communication_timed_out pulses exactly 750000 cycles after clock release; both lines return to z.
- Send 0xFF with the device not pulling DAT low at edge 11: error_no_ack pulses; command_was_sent stays 0.
- Request collision and reset mid-packet:
  - Assert send_command=1 with 0xAA while busy; the wire still carries the first byte.
  - Assert reset at bit 4: PS2_CLK and PS2_DAT go to z in the same cycle, with no pulses.
  - A new 0xED sends cleanly afterwards.
